// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU load/store path.
// A request is taken under a level req/ack handshake. After LATENCY cycles
// the byte/half/word access runs on an internal word array. Misaligned or
// reserved-size accesses skip the wait and complete with err set.
//
// Ports
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   req    request valid (level); held with qualifiers until ack
//   we     1 = write, 0 = read
//   size   00 byte, 01 half, 10 word, 11 reserved
//   addr   byte address (bits above ADDR_WIDTH+1 ignored)
//   wdata  right-justified write data
//   ack    one-cycle completion pulse
//   rdata  zero-extended read data, valid while ack=1
//   err    completion with error, only while ack=1
module mem_responder #(
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t                state, state_nxt;
   logic [3:0]            cnt, cnt_nxt;
   logic                  accept, access;
   logic                  illegal;

   logic                  cap_we;
   logic [1:0]            cap_size;
   logic [ADDR_WIDTH+1:0] cap_addr;
   logic [31:0]           cap_wdata;
   logic                  cap_err;

   logic [31:0]           mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] idx;
   logic [31:0]           rd_word, rd_sh, rd_ext;
   logic [3:0]            be;
   logic [31:0]           wlane;

   // Upper address bits only wrap the array; they carry no information.
   logic unused_addr;
   assign unused_addr = ^addr[31:ADDR_WIDTH+2];

   always_comb begin
      illegal = 1'b0;
      case (size)
         2'b01:   illegal = addr[0];
         2'b10:   illegal = (addr[1:0] != 2'b00);
         2'b11:   illegal = 1'b1;
         default: illegal = 1'b0;
      endcase
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      access    = 1'b0;
      ack       = 1'b0;
      case (state)
         IDLE: if (req) begin
            accept = 1'b1;
            if (illegal) begin
               state_nxt = DONE;
            end else begin
               state_nxt = WAIT;
               cnt_nxt   = 4'(LATENCY - 1);
            end
         end
         WAIT: begin
            if (cnt != 4'd0) begin
               cnt_nxt = cnt - 4'd1;
            end else begin
               access    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            ack       = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign err = ack & cap_err;

   // ---------------- request capture / read result ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_we    <= 1'b0;
         cap_size  <= 2'b00;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_err   <= 1'b0;
         rdata     <= '0;
      end else begin
         if (accept) begin
            cap_we    <= we;
            cap_size  <= size;
            cap_addr  <= addr[ADDR_WIDTH+1:0];
            cap_wdata <= wdata;
            cap_err   <= illegal;
            if (illegal) rdata <= '0;
         end
         if (access) rdata <= cap_we ? 32'd0 : rd_ext;
      end
   end

   // ---------------- array access ----------------
   assign idx     = cap_addr[ADDR_WIDTH+1:2];
   assign rd_word = mem[idx];
   // Legal accesses are aligned, so one shift by the byte offset lines up
   // byte, half and word results alike.
   assign rd_sh   = rd_word >> {cap_addr[1:0], 3'b000};

   always_comb begin
      rd_ext = rd_sh;
      be     = 4'b1111;
      wlane  = cap_wdata;
      case (cap_size)
         2'b00: begin
            rd_ext = {24'd0, rd_sh[7:0]};
            be     = 4'b0001 << cap_addr[1:0];
            wlane  = {4{cap_wdata[7:0]}};
         end
         2'b01: begin
            rd_ext = {16'd0, rd_sh[15:0]};
            be     = cap_addr[1] ? 4'b1100 : 4'b0011;
            wlane  = {2{cap_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // The array is never reset; a reset during WAIT leaves access low, so an
   // in-flight write simply never happens.
   always_ff @(posedge clk) begin
      if (access && cap_we) begin
         for (int k = 0; k < 4; k++) begin
            if (be[k]) mem[idx][8*k +: 8] <= wlane[8*k +: 8];
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req, we;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic        ack, err;
   logic [31:0] rdata;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   mem_responder #(.ADDR_WIDTH(8), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
      .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
      end
   endtask

   // Monitor: every ack pops one expectation; err must never show without ack.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (ack === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack rdata=%h err=%b expected=no_ack", rdata, err);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("ack_err", 32'(err), 32'(e.err));
               chk("ack_rdata", rdata, e.rdata);
            end
         end else begin
            chk("err_without_ack", 32'(err), 32'd0);
         end
      end
   end

   // Issue one request, wait for its ack, return cycles from acceptance to ack.
   task automatic access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input logic e_err, input logic [31:0] e_rd,
                         output int lat);
      exp_t e;
      @(negedge clk);
      req = 1'b1; we = w; size = sz; addr = a; wdata = d;
      e.err = e_err; e.rdata = e_rd;
      exp_q.push_back(e);
      @(posedge clk); #1;
      lat = 0;
      while (ack !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (ack !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout actual=no_ack expected=ack addr=%h", a);
      end
      @(negedge clk);
      req = 1'b0;
   endtask

   initial begin
      int lat;
      exp_t e;
      reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      chk("reset_ack", 32'(ack), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      chk("reset_rdata", rdata, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Reset during WAIT drops the write and clears outputs at once.
      access(1'b1, 2'b10, 32'h10, 32'h11223344, 1'b0, 32'h0, lat);
      access(1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 32'h11223344, lat);
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'hDEADBEEF;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midreset_ack", 32'(ack), 32'd0);
      chk("midreset_err", 32'(err), 32'd0);
      chk("midreset_rdata", rdata, 32'd0);
      req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      access(1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 32'h11223344, lat);

      // Latency and word access
      access(1'b1, 2'b10, 32'h40, 32'h12345678, 1'b0, 32'h0, lat);
      chk("write_latency", 32'(lat), 32'(LAT));
      access(1'b0, 2'b10, 32'h40, 32'hFFFFFFFF, 1'b0, 32'h12345678, lat);
      chk("read_latency", 32'(lat), 32'(LAT));

      // Sub-word writes (upper wdata bits must be ignored)
      access(1'b1, 2'b00, 32'h41, 32'hFFFFFFAA, 1'b0, 32'h0, lat);
      access(1'b1, 2'b01, 32'h42, 32'h5555BBCC, 1'b0, 32'h0, lat);
      access(1'b0, 2'b10, 32'h40, 32'h0, 1'b0, 32'hBBCCAA78, lat);

      // Sub-word reads
      access(1'b0, 2'b00, 32'h43, 32'h0, 1'b0, 32'h000000BB, lat);
      access(1'b0, 2'b01, 32'h40, 32'h0, 1'b0, 32'h0000AA78, lat);
      access(1'b0, 2'b01, 32'h42, 32'h0, 1'b0, 32'h0000BBCC, lat);

      // Error cases: writes that must not land, plus a reserved read
      access(1'b1, 2'b10, 32'h42, 32'h99999999, 1'b1, 32'h0, lat);
      chk("err_word_latency_le1", 32'(lat <= 1), 32'd1);
      access(1'b1, 2'b01, 32'h41, 32'h99999999, 1'b1, 32'h0, lat);
      chk("err_half_latency_le1", 32'(lat <= 1), 32'd1);
      access(1'b0, 2'b11, 32'h40, 32'h0, 1'b1, 32'h0, lat);
      chk("err_rsvd_latency_le1", 32'(lat <= 1), 32'd1);
      access(1'b0, 2'b10, 32'h40, 32'h0, 1'b0, 32'hBBCCAA78, lat);

      // Wrap at 1 KiB and back-to-back with req held across ack
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h400; wdata = 32'h0000CAFE;
      e.err = 1'b0; e.rdata = 32'h0;
      exp_q.push_back(e);
      @(posedge clk); #1;
      lat = 0;
      while (ack !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("b2b_first_latency", 32'(lat), 32'(LAT));
      @(negedge clk);
      we = 1'b0; addr = 32'h0; wdata = 32'hFFFFFFFF;
      e.err = 1'b0; e.rdata = 32'h0000CAFE;
      exp_q.push_back(e);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (ack !== 1'b1 && lat < 20);
      chk("b2b_spacing", 32'(lat), 32'(LAT + 2));
      @(negedge clk);
      req = 1'b0;

      repeat (6) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
